// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int NUM_REQ       = 2;
    localparam int DEPTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the data-memory arbiter.
// DMEM_ARB_RR_EN defined: round-robin on contention; undefined: port 0 has fixed priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_winner,
    output logic               winner
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        // NOTE: give every combinational output a default first so no path infers a latch.
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_winner;
        end else begin
            winner = req[1];
        end
    end
`else
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
    assign winner             = req[1] & ~req[0];
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the CPU (port 0) and debug/loader (port 1).
// Build option DMEM_ARB_RR_EN selects round-robin arbitration in dmem_arb_pick.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] we,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [DATA_W-1:0]  wdata0,
    input  logic [DATA_W-1:0]  wdata1,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               err,
    output logic [DATA_W-1:0]  rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd_en,
    output logic               mem_wr_en,
    output logic [DATA_W-1:0]  mem_wr_data,
    input  logic [DATA_W-1:0]  mem_rd_data
);

    state_t            state;
    state_t            state_nxt;
    logic              winner;
    logic              last_winner;
    logic              lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range;
    logic              start;

    dmem_arb_pick u_pick (
        .req         (req),
        .last_winner (last_winner),
        .winner      (winner)
    );

    assign start       = (state == ST_IDLE) && (|req);
    assign in_range    = (lat_addr < ADDR_W'(DEPTH));
    assign mem_addr    = lat_addr;
    assign mem_wr_data = lat_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (start) state_nxt = ST_ACCESS;
            ST_ACCESS:  state_nxt = (!lat_we && in_range) ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Enables are decoded from state so an async reset drops them immediately.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        unique case (state)
            ST_ACCESS: begin
                mem_wr_en = in_range &  lat_we;
                mem_rd_en = in_range & ~lat_we;
            end
            ST_CAPTURE: mem_rd_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            last_winner <= 1'b1;
            lat_port    <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= 1'b0;
            if (start) begin
                gnt[winner] <= 1'b1;
                last_winner <= winner;
                lat_port    <= winner;
                lat_we      <= we[winner];
                lat_addr    <= winner ? addr1 : addr0;
                lat_wdata   <= winner ? wdata1 : wdata0;
            end
            // Writes and rejected accesses finish straight out of ACCESS.
            if (state == ST_ACCESS && (lat_we || !in_range)) begin
                done[lat_port] <= 1'b1;
                err            <= ~in_range;
                if (!in_range) rdata <= '0;
            end
            if (state == ST_CAPTURE) begin
                done[lat_port] <= 1'b1;
                rdata          <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a rising-rd_en memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, gnt, done;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        err, mem_rd_en, mem_wr_en;
    logic [31:0] rdata, mem_addr, mem_wr_data, mem_rd_data;

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    logic [31:0] mem [32];
    logic        rd_prev;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .we          (we),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // Memory: synchronous write, output refreshed only on a rising rd_en.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[4:0]] <= mem_wr_data;
        if (mem_rd_en && !rd_prev) mem_rd_data <= mem[mem_addr[4:0]];
        rd_prev <= mem_rd_en;
    end

    always @(negedge clk) begin
        if (gnt == 2'b11 || done == 2'b11 || (err && done == 2'b00)) viol++;
    end

    task automatic do_op(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int gnt_at, output int done_at, output logic [31:0] rd,
                         output logic e, output int wr_cyc, output int rd_cyc);
        gnt_at = -1; done_at = -1; rd = '0; e = 1'b0; wr_cyc = 0; rd_cyc = 0;
        we[p] = w;
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else        begin addr1 = a; wdata1 = d; end
        req[p] = 1'b1;
        for (int c = 1; c <= 12 && done_at < 0; c++) begin
            @(negedge clk);
            if (mem_wr_en) wr_cyc++;
            if (mem_rd_en) rd_cyc++;
            if (gnt[p] && gnt_at < 0) begin gnt_at = c; req[p] = 1'b0; end
            if (done[p]) begin done_at = c; rd = rdata; e = err; end
        end
        req[p] = 1'b0;
        tests++;
        if (done_at < 0) begin fails++; $display("FAIL op_timeout port%0d addr %0d: no done within 12 cycles", p, a); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        tests++; if (done !== 2'b00 || err !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %b/%b expected 00/0", done, err); end
        tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        tests++; if ({mem_rd_en, mem_wr_en} !== 2'b00) begin fails++; $display("FAIL reset_enables: got %b expected 00", {mem_rd_en, mem_wr_en}); end
        tests++; if (mem_addr !== 32'h0 || mem_wr_data !== 32'h0) begin fails++; $display("FAIL reset_mem_bus: got %h/%h expected 0/0", mem_addr, mem_wr_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        int ga, da, wc, rc; logic [31:0] rd; logic e;
        do_op(0, 1'b1, 32'd3, 32'h6, ga, da, rd, e, wc, rc);
        tests++; if (ga !== 1) begin fails++; $display("FAIL wr_gnt_cycle: got %0d expected 1", ga); end
        tests++; if (da !== 2) begin fails++; $display("FAIL wr_done_cycle: got %0d expected 2", da); end
        tests++; if (wc !== 1 || rc !== 0) begin fails++; $display("FAIL wr_enables: wr %0d rd %0d expected 1 0", wc, rc); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL wr_err: got %b expected 0", e); end
        tests++; if (mem[3] !== 32'h6) begin fails++; $display("FAIL wr_commit: mem[3] %h expected 6", mem[3]); end
    endtask

    task automatic test_read();
        int ga, da, wc, rc; logic [31:0] rd; logic e;
        do_op(0, 1'b0, 32'd3, 32'h0, ga, da, rd, e, wc, rc);
        tests++; if (ga !== 1) begin fails++; $display("FAIL rd_gnt_cycle: got %0d expected 1", ga); end
        tests++; if (da !== 3) begin fails++; $display("FAIL rd_done_cycle: got %0d expected 3", da); end
        tests++; if (rc !== 2 || wc !== 0) begin fails++; $display("FAIL rd_enables: rd %0d wr %0d expected 2 0", rc, wc); end
        tests++; if (rd !== 32'h6 || e !== 1'b0) begin fails++; $display("FAIL rd_data: got %h err %b expected 6 err 0", rd, e); end
    endtask

    task automatic test_arbitration();
        int gseq [4] = '{-1, -1, -1, -1};
        int dseq [4] = '{-1, -1, -1, -1};
        logic [31:0] dval [4];
        int ng = 0, nd = 0, exp_p;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        we = 2'b00; addr0 = 32'd10; addr1 = 32'd11; req = 2'b11;
        for (int c = 0; c < 60 && nd < 4; c++) begin
            @(negedge clk);
            if (gnt != 2'b00 && ng < 4) begin gseq[ng] = gnt[1] ? 1 : 0; ng++; end
            if (done != 2'b00 && nd < 4) begin dseq[nd] = done[1] ? 1 : 0; dval[nd] = rdata; nd++; end
        end
        req = 2'b00;
        repeat (5) @(negedge clk);
        tests++; if (nd !== 4) begin fails++; $display("FAIL arb_done_count: got %0d expected 4", nd); end
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
            exp_p = k % 2;
`else
            exp_p = 0;
`endif
            tests++; if (gseq[k] !== exp_p) begin fails++; $display("FAIL arb_grant_%0d: port %0d expected %0d", k, gseq[k], exp_p); end
            tests++; if (dseq[k] !== exp_p) begin fails++; $display("FAIL arb_done_%0d: port %0d expected %0d", k, dseq[k], exp_p); end
            tests++; if (nd > k && dval[k] !== (exp_p == 1 ? 32'h100B : 32'h100A)) begin fails++; $display("FAIL arb_rdata_%0d: got %h expected %h", k, dval[k], (exp_p == 1 ? 32'h100B : 32'h100A)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [2] = '{32'hX, 32'hX};
        int nd = 0, gn = 0, rises = 0, gap = 0;
        logic prev = 1'b0;
        we[1] = 1'b0; addr1 = 32'd1; req[1] = 1'b1;
        for (int c = 0; c < 20 && nd < 2; c++) begin
            @(negedge clk);
            if (gnt[1]) begin gn++; if (gn == 1) addr1 = 32'd2; else req[1] = 1'b0; end
            if (done[1]) begin vals[nd] = rdata; nd++; end
            if (mem_rd_en && !prev) rises++;
            if (!mem_rd_en && rises == 1) gap++;
            prev = mem_rd_en;
        end
        req[1] = 1'b0;
        @(negedge clk);
        tests++; if (nd !== 2) begin fails++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
        tests++; if (vals[0] !== 32'h1001) begin fails++; $display("FAIL b2b_rdata0: got %h expected 00001001", vals[0]); end
        tests++; if (vals[1] !== 32'h1002) begin fails++; $display("FAIL b2b_rdata1: got %h expected 00001002", vals[1]); end
        tests++; if (rises !== 2 || gap < 1) begin fails++; $display("FAIL b2b_rd_en_gap: rises %0d gap %0d expected 2 and >=1", rises, gap); end
    endtask

    task automatic test_out_of_range();
        int ga, da, wc, rc; logic [31:0] rd; logic e;
        do_op(1, 1'b1, 32'd40, 32'hDEAD, ga, da, rd, e, wc, rc);
        tests++; if (ga !== 1 || da !== 2) begin fails++; $display("FAIL oor_wr_timing: gnt %0d done %0d expected 1 2", ga, da); end
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL oor_wr_err: err %b rdata %h expected 1 0", e, rd); end
        tests++; if (wc !== 0) begin fails++; $display("FAIL oor_wr_enable: got %0d cycles expected 0", wc); end
        tests++; if (mem[8] !== 32'h1008) begin fails++; $display("FAIL oor_wr_alias: mem[8] %h expected 00001008", mem[8]); end
        do_op(0, 1'b0, 32'd32, 32'h0, ga, da, rd, e, wc, rc);
        tests++; if (e !== 1'b1 || rc !== 0 || da !== 2) begin fails++; $display("FAIL oor_rd_32: err %b rd_cyc %0d done %0d expected 1 0 2", e, rc, da); end
        do_op(0, 1'b0, 32'd31, 32'h0, ga, da, rd, e, wc, rc);
        tests++; if (e !== 1'b0 || rd !== 32'h101F || da !== 3) begin fails++; $display("FAIL edge_rd_31: err %b rdata %h done %0d expected 0 0000101f 3", e, rd, da); end
    endtask

    task automatic test_reset_mid_op();
        int ga, da, wc, rc; logic [31:0] rd; logic e;
        logic saw_done = 1'b0;
        we[0] = 1'b1; addr0 = 32'd5; wdata0 = 32'hAA; req[0] = 1'b1;
        @(negedge clk);
        tests++; if (gnt[0] !== 1'b1 || mem_wr_en !== 1'b1) begin fails++; $display("FAIL rst_mid_access: gnt %b wr_en %b expected 1 1", gnt[0], mem_wr_en); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (mem_wr_en !== 1'b0 || gnt !== 2'b00) begin fails++; $display("FAIL rst_async_drop: wr_en %b gnt %b expected 0 00", mem_wr_en, gnt); end
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done != 2'b00) saw_done = 1'b1;
        end
        tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL rst_no_done: saw %b expected 0", saw_done); end
        do_op(0, 1'b0, 32'd5, 32'h0, ga, da, rd, e, wc, rc);
        tests++; if (rd !== 32'h1005) begin fails++; $display("FAIL rst_write_dropped: got %h expected 00001005", rd); end
    endtask

    task automatic test_protocol();
        tests++; if (viol !== 0) begin fails++; $display("FAIL onehot_err_protocol: %0d bad cycles expected 0", viol); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
        mem_rd_data = '0;
        rd_prev = 1'b0;
        req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_op();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
